// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between NUM_REQ
// byte producers. One byte is latched per grant, tx_start pulses for one
// cycle, and the frame is tracked through tx_busy before re-arbitrating.
//
// Optional build macro UART_ARB_TIMEOUT_EN: adds a busy-rise timeout in
// WAIT_BUSY and the sticky arb_err output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; grant when tx is free and a request waits
// WAIT_BUSY | tx_start issued, waiting for uart_tx_busy to rise
// WAIT_DONE | frame in progress, waiting for uart_tx_busy to fall
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_data,
    output logic                 uart_tx_start,
    input  logic                 uart_tx_busy,
    output logic [ID_W-1:0]      grant_id,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                 arb_err,
`endif
    output logic                 active
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic            found;
    logic [ID_W-1:0] winner;
    logic [7:0]      win_data;
    logic            grant;
    logic            done;
    logic            tmo;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;
`endif

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                winner   = ID_W'(idx);
                win_data = req_data[8*idx +: 8];
            end
        end
    end

    // Next-state decode; grant/done/tmo are the events the register block acts on.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (!uart_tx_busy && found) begin
                    grant     = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (timer == '0) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered outputs; grant latches the winner's byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= ID_W'(NUM_REQ - 1);
            req_ready     <= '0;
            uart_data     <= 8'h00;
            uart_tx_start <= 1'b0;
            grant_id      <= '0;
            active        <= 1'b0;
        end else begin
            state         <= state_nxt;
            req_ready     <= grant ? (NUM_REQ'(1) << winner) : '0;
            uart_tx_start <= grant;
            if (grant) begin
                uart_data  <= win_data;
                grant_id   <= winner;
                last_grant <= winner;
                active     <= 1'b1;
            end else if (done || tmo) begin
                active     <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Down-counter armed at grant; reaching zero with busy still low aborts the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            arb_err <= 1'b0;
        end else begin
            if (grant) begin
                timer <= TMR_W'(TIMEOUT - 1);
            end else if (state == WAIT_BUSY && !uart_tx_busy && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (tmo) begin
                arb_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_data;
    logic                 uart_tx_start;
    logic                 uart_tx_busy = 1'b0;
    logic [ID_W-1:0]      grant_id;
    logic                 active;
`ifdef UART_ARB_TIMEOUT_EN
    logic                 arb_err;
`endif

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .uart_data     (uart_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy),
        .grant_id      (grant_id),
`ifdef UART_ARB_TIMEOUT_EN
        .arb_err       (arb_err),
`endif
        .active        (active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int           start_cnt = 0;
    int           dbl_cnt   = 0;
    int           ready_cnt [NUM_REQ] = '{default: 0};
    logic         prev_start = 1'b0;
    logic [1:0]   log_id [$];
    logic [7:0]   log_data [$];

    logic model_en   = 1'b0;
    logic start_prev = 1'b0;
    int   bcnt       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: busy rises one cycle after tx_start, stays high 10 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_en) begin
                if (start_prev) begin
                    uart_tx_busy = 1'b1;
                    bcnt = 10;
                end else if (uart_tx_busy) begin
                    bcnt--;
                    if (bcnt == 0) uart_tx_busy = 1'b0;
                end
            end
            start_prev = uart_tx_start;
        end
    end

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (uart_tx_start) begin
            start_cnt++;
            if (prev_start) dbl_cnt++;
            log_id.push_back(grant_id);
            log_data.push_back(uart_data);
        end
        prev_start = uart_tx_start;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) ready_cnt[i]++;
    end

    task automatic do_reset();
        reset_n = 1'b0;
        model_en = 1'b0;
        uart_tx_busy = 1'b0;
        req_valid = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_en = 1'b1;
    endtask

    task automatic wait_ready(input int idx, input int bound);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (req_ready[idx]) seen = 1'b1;
        end
        check_eq("ready_seen", 32'(seen), 32'd1);
    endtask

    task automatic drop(input int idx);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_inactive(input int bound, output int cycles);
        logic gone;
        gone = 1'b0;
        cycles = 0;
        for (int c = 0; c < bound && !gone; c++) begin
            @(negedge clk);
            if (active) cycles++;
            else gone = 1'b1;
        end
        check_eq("idle_seen", 32'(gone), 32'd1);
    endtask

    initial begin
        int sc, rc, cyc;
        logic seen5;

        // reset values
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_data", 32'(uart_data), 32'h00);
        check_eq("rst_start", 32'(uart_tx_start), 32'h0);
        check_eq("rst_grant", 32'(grant_id), 32'h0);
        check_eq("rst_active", 32'(active), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
        check_eq("rst_err", 32'(arb_err), 32'h0);
`endif
        do_reset();

        // single request from requester 2
        sc = start_cnt; rc = ready_cnt[2];
        @(posedge clk); #1;
        req_data[23:16] = 8'hA5;
        req_valid[2] = 1'b1;
        wait_ready(2, 20);
        check_eq("t1_grant", 32'(grant_id), 32'd2);
        check_eq("t1_data", 32'(uart_data), 32'hA5);
        check_eq("t1_start", 32'(uart_tx_start), 32'd1);
        check_eq("t1_ready", 32'(req_ready), 32'b0100);
        check_eq("t1_active", 32'(active), 32'd1);
        drop(2);
        wait_inactive(60, cyc);
        check_eq("t1_active_len", 32'(cyc + 1), 32'd12);
        check_eq("t1_starts", 32'(start_cnt - sc), 32'd1);
        check_eq("t1_readys", 32'(ready_cnt[2] - rc), 32'd1);

        // all four requesting continuously from reset
        do_reset();
        log_id.delete();
        log_data.delete();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        seen5 = 1'b0;
        for (int c = 0; c < 200 && !seen5; c++) begin
            @(negedge clk);
            if (log_id.size() >= 5) seen5 = 1'b1;
        end
        check_eq("t2_five_frames", 32'(seen5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_rr_id", 32'(log_id[i]), 32'(i % 4));
            check_eq("t2_rr_data", 32'(log_data[i]), 32'h10 + 32'(i % 4));
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_inactive(60, cyc);
        check_eq("t2_single_start", 32'(dbl_cnt), 32'd0);

        // busy already high while requester 1 waits
        @(posedge clk); #1;
        model_en = 1'b0;
        uart_tx_busy = 1'b1;
        req_data[15:8] = 8'h5C;
        req_valid[1] = 1'b1;
        sc = start_cnt; rc = ready_cnt[1];
        repeat (6) @(negedge clk);
        check_eq("t3_no_start", 32'(start_cnt - sc), 32'd0);
        check_eq("t3_no_ready", 32'(ready_cnt[1] - rc), 32'd0);
        check_eq("t3_not_active", 32'(active), 32'd0);
        @(posedge clk); #1;
        uart_tx_busy = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        check_eq("t3_no_early", 32'(uart_tx_start), 32'd0);
        @(negedge clk);
        check_eq("t3_start", 32'(uart_tx_start), 32'd1);
        check_eq("t3_grant", 32'(grant_id), 32'd1);
        check_eq("t3_data", 32'(uart_data), 32'h5C);
        check_eq("t3_ready", 32'(req_ready), 32'b0010);
        drop(1);
        wait_inactive(60, cyc);

        // requester 3 withdraws before grant, requester 1 pending
        @(posedge clk); #1;
        model_en = 1'b0;
        uart_tx_busy = 1'b1;
        req_data[31:24] = 8'h3C;
        req_data[15:8] = 8'h77;
        req_valid[3] = 1'b1;
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        sc = start_cnt; rc = ready_cnt[3];
        @(posedge clk); #1;
        uart_tx_busy = 1'b0;
        model_en = 1'b1;
        wait_ready(1, 10);
        check_eq("t4_grant", 32'(grant_id), 32'd1);
        check_eq("t4_data", 32'(uart_data), 32'h77);
        drop(1);
        wait_inactive(60, cyc);
        repeat (20) @(negedge clk);
        check_eq("t4_no_ready3", 32'(ready_cnt[3] - rc), 32'd0);
        check_eq("t4_one_frame", 32'(start_cnt - sc), 32'd1);

        // reset in WAIT_DONE
        @(posedge clk); #1;
        req_data[23:16] = 8'hE7;
        req_valid[2] = 1'b1;
        wait_ready(2, 10);
        drop(2);
        repeat (4) @(negedge clk);
        check_eq("t5_pre_active", 32'(active), 32'd1);
        #2;
        reset_n = 1'b0;
        model_en = 1'b0;
        uart_tx_busy = 1'b0;
        #1;
        check_eq("t5_rst_ready", 32'(req_ready), 32'h0);
        check_eq("t5_rst_data", 32'(uart_data), 32'h00);
        check_eq("t5_rst_start", 32'(uart_tx_start), 32'h0);
        check_eq("t5_rst_grant", 32'(grant_id), 32'h0);
        check_eq("t5_rst_active", 32'(active), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        req_data[7:0] = 8'h01;
        req_data[15:8] = 8'h02;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        reset_n = 1'b1;
        model_en = 1'b1;
        wait_ready(0, 10);
        check_eq("t5_grant0", 32'(grant_id), 32'd0);
        check_eq("t5_data0", 32'(uart_data), 32'h01);
        drop(0);
        wait_ready(1, 40);
        check_eq("t5_grant1", 32'(grant_id), 32'd1);
        check_eq("t5_data1", 32'(uart_data), 32'h02);
        drop(1);
        wait_inactive(60, cyc);

`ifdef UART_ARB_TIMEOUT_EN
        // busy never rises: timeout after 16 cycles, sticky error
        @(posedge clk); #1;
        model_en = 1'b0;
        uart_tx_busy = 1'b0;
        req_data[31:24] = 8'h99;
        req_valid[3] = 1'b1;
        wait_ready(3, 10);
        drop(3);
        wait_inactive(60, cyc);
        check_eq("t6_tmo_len", 32'(cyc + 1), 32'd16);
        check_eq("t6_err", 32'(arb_err), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("t6_err_sticky", 32'(arb_err), 32'd1);
        @(posedge clk); #1;
        model_en = 1'b1;
        req_data[7:0] = 8'h42;
        req_valid[0] = 1'b1;
        wait_ready(0, 10);
        check_eq("t6_grant", 32'(grant_id), 32'd0);
        check_eq("t6_data", 32'(uart_data), 32'h42);
        drop(0);
        wait_inactive(60, cyc);
        check_eq("t6_err_after", 32'(arb_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx transmitter between NUM_REQ byte producers.
- Sits between the requesters (command logic, status reporters, debug taps) and the uart_tx data/tx_start/tx_busy interface.
- Latches one byte per grant, issues a single-cycle tx_start, then tracks tx_busy through the whole frame before arbitrating again.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
- TIMEOUT, 16, cycles to wait for uart_tx_busy to rise after tx_start (used only with UART_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous reset, active-low
- req_valid  input  NUM_REQ  per-requester byte-pending flag
- req_data  input  8*NUM_REQ  byte for requester i on bits [8*i+7:8*i]
- req_ready  output  NUM_REQ  one-cycle accept pulse; byte is latched
- uart_data  output  8  to uart_tx data
- uart_tx_start  output  1  to uart_tx tx_start
- uart_tx_busy  input  1  from uart_tx tx_busy
- grant_id  output  ID_W  index of the requester currently being served
- active  output  1  high from accept until the frame completes
- arb_err  output  1  sticky timeout flag (present only with UART_ARB_TIMEOUT_EN)

Behaviour:
- All outputs are registered. Reset values: req_ready=0, uart_data=0x00, uart_tx_start=0, grant_id=0, active=0, arb_err=0. Internal last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- Handshake: a requester holds req_valid=1 with req_data stable until it sees req_ready=1. It drops or changes them on the edge after. It may withdraw req_valid before being granted; the arbiter simply re-evaluates.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: when uart_tx_busy=0 and any req_valid=1, select the winner w. The search runs last_grant+1, last_grant+2, … and wraps modulo NUM_REQ. On that same edge:
  - req_ready[w]<=1 and uart_tx_start<=1
  - uart_data<=req_data[w], grant_id<=w, last_grant<=w, active<=1
  - go to WAIT_BUSY
- If uart_tx_busy=1 while in IDLE, no grant is issued.
- WAIT_BUSY: req_ready and uart_tx_start return to 0 on the first edge, so each is exactly one cycle wide. When uart_tx_busy=1, go to WAIT_DONE.
- WAIT_DONE: when uart_tx_busy=0, set active<=0 and go to IDLE. The next grant can occur no earlier than the following edge, giving at least one idle cycle between frames.
- uart_data and grant_id hold their values from accept until the next accept.
- Latency: req_valid is sampled at edge N. req_ready and uart_tx_start are high from edge N to edge N+1. tx_busy rises after edge N+1.
- Simultaneous requests are served one per frame in round-robin order. A requester that re-asserts immediately waits behind all other pending requesters.
- Reset mid-frame forces IDLE and reset values immediately. The uart_tx is assumed reset by the same reset tree.
- Without the optional feature, a stuck-low uart_tx_busy hangs the FSM in WAIT_BUSY by design.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY.
  - If uart_tx_busy has not risen after TIMEOUT cycles, the FSM returns to IDLE with active<=0 and arb_err<=1.
  - arb_err is sticky until reset.
  - The failed byte is dropped, not retried.
- Undefined: no counter, no arb_err port, WAIT_BUSY waits indefinitely.

Test Plan:
- Single request: req_valid[2]=1, data 0xA5, busy model rises 1 cycle after start and falls 10 cycles later. Expect one req_ready[2] pulse, uart_data=0xA5, one-cycle uart_tx_start, grant_id=2, and active high until busy falls.
- All four requesting continuously from reset with bytes 0x10..0x13. Expect grants in order 0,1,2,3,0, matching uart_data sequence, and exactly one tx_start per frame.
- Busy already high while req_valid[1]=1. Expect no req_ready or tx_start until busy is low; grant occurs on the first edge after busy is sampled low.
- Requester 3 withdraws req_valid before grant while requester 1 is pending. Expect requester 1 to be served, with no req_ready[3] and no spurious frame.
- Assert reset_n=0 in WAIT_DONE. Expect all outputs at reset values immediately, and next grant to requester 0 after release.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=16, busy held low after start. Expect return to IDLE after 16 cycles with arb_err=1 (sticky), after which the next request is served normally.
